// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types and sizing helpers.
package arith_pkg;

  typedef enum logic {IDLE, RUN} chunk_add_state_t;

  function automatic int unsigned num_chunks(input int unsigned data_width,
                                             input int unsigned chunk_width);
    return data_width / chunk_width;
  endfunction

  // Index counter width; never below one bit so the degenerate case still has a register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_adder_full_adder.sv
// Combinational CHUNK_WIDTH-bit adder slice with carry in/out.
module chunk_full_adder #(
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [CHUNK_WIDTH-1:0] s,
  output logic                   cout
);

  logic [CHUNK_WIDTH:0] partial;

  always_comb begin
    partial = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, cin};
  end

  assign s    = partial[CHUNK_WIDTH-1:0];
  assign cout = partial[CHUNK_WIDTH];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle unsigned adder, one CHUNK_WIDTH slice per cycle, LSB chunk first.
// Define CHUNKED_ADDER_SATURATE_EN to clamp sum to all-ones on carry-out.
module chunked_adder
  import arith_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] augend,
  input  logic [DATA_WIDTH-1:0] addend,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  complete,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned NUM_CHUNKS = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
  localparam int unsigned IDX_W      = idx_width(NUM_CHUNKS);

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_width_check
    $error("DATA_WIDTH must be an integer multiple of CHUNK_WIDTH");
  end

  chunk_add_state_t      state_q, state_d;
  logic [DATA_WIDTH-1:0] aug_q, aug_d;
  logic [DATA_WIDTH-1:0] add_q, add_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  complete_q, complete_d;
  logic                  overflow_q, overflow_d;

  logic [31:0]            base;
  logic [CHUNK_WIDTH-1:0] fa_a, fa_b, fa_s;
  logic                   fa_cout;
  logic                   last_chunk;

  assign base       = 32'(idx_q) * CHUNK_WIDTH;
  assign fa_a       = aug_q[base +: CHUNK_WIDTH];
  assign fa_b       = add_q[base +: CHUNK_WIDTH];
  assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));

  chunk_full_adder #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_fa (
    .a   (fa_a),
    .b   (fa_b),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_cout)
  );

  always_comb begin
    state_d    = state_q;
    aug_d      = aug_q;
    add_d      = add_q;
    res_d      = res_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    complete_d = complete_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aug_d      = augend;
          add_d      = addend;
          carry_d    = 1'b0;
          idx_d      = '0;
          complete_d = 1'b0;
          overflow_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        res_d[base +: CHUNK_WIDTH] = fa_s;
        carry_d = fa_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          // res_d already holds the final chunk written just above.
          sum_d = res_d;
`ifdef CHUNKED_ADDER_SATURATE_EN
          if (fa_cout) begin
            sum_d = '1;
          end
`endif
          overflow_d = fa_cout;
          complete_d = 1'b1;
          idx_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      aug_q      <= '0;
      add_q      <= '0;
      res_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      aug_q      <= aug_d;
      add_q      <= add_d;
      res_q      <= res_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      complete_q <= complete_d;
      overflow_q <= overflow_d;
    end
  end

  assign sum      = sum_q;
  assign complete = complete_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == RUN);

endmodule
